intersection_phase_scheduler: RTL and testbench
===============================================

Name: intersection_phase_scheduler

Overview:
Two-road intersection sequencer (NS road, EW road) plus a pedestrian phase.
- Drives two red/yellow/green signal heads and a walk lamp from one Moore FSM with a shared down-counter.
- Supports vehicle-actuated green extension and a latched pedestrian request/acknowledge.
- Sits above the single-head light controller: it decides which head is green and when.

Parameters:
GREEN_CYC, 8, minimum green duration per road in clk cycles (>=1)
YELLOW_CYC, 2, yellow duration (>=1)
ALLRED_CYC, 1, all-red clearance duration (>=1)
WALK_CYC, 4, pedestrian walk duration (>=1)
MAX_EXT, 2, maximum green extensions per green phase (>=0)
CNT_W, 4, timer width; must hold max(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, WALK_CYC)-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
ns_car  input  1  NS vehicle-present sensor, level, synchronous to clk
ew_car  input  1  EW vehicle-present sensor, level
ped_req  input  1  pedestrian request; any cycle high sets the pending flag
ped_ack  output  1  one-cycle pulse in the first cycle of PED_WALK
ns_red / ns_yellow / ns_green  output  1 each  NS signal head
ew_red / ew_yellow / ew_green  output  1 each  EW signal head
walk  output  1  pedestrian walk lamp
phase  output  3  current state code (debug and visibility)

Behaviour:
- States and codes: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, PED_WALK=6. Code 7 is illegal and goes to ALLRED_B with timer 0.
- Moore outputs decoded from the state register only.
  - Each head is one-hot: red unless its own GREEN or YELLOW state.
  - walk=1 only in PED_WALK; both heads red there.
- Reset (async assert, sync release):
  - state=ALLRED_B, timer=0, ext_cnt=0, ped_pend=0.
  - Outputs: ns_red=ew_red=1, all other lights 0, walk=0, ped_ack=0, phase=5.
- Timer: on state entry, load (duration-1); decrement each cycle; leave the state on the edge where timer==0. Each state therefore lasts exactly its duration in cycles.
- Transitions on timer==0:
  - NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B.
  - ALLRED_B -> PED_WALK if ped_pend, else NS_GREEN.
  - PED_WALK -> NS_GREEN.
- First rising edge after rst deasserts: ALLRED_B -> NS_GREEN (or PED_WALK if ped_req was high that cycle).
- ped_pend:
  - Set by ped_req=1 in any cycle.
  - Cleared on the edge entering PED_WALK.
  - If ped_req=1 on that same edge, it stays set and is served next cycle round.
  - ped_req during PED_WALK sets it for the next round.
- ped_ack is registered: high exactly the first cycle in PED_WALK.
- Green extension (SCHED_GAPOUT_EN only), evaluated when a green's timer==0:
  - If the opposing sensor=0, ped_pend=0 and ext_cnt<MAX_EXT: reload timer with GREEN_CYC-1, increment ext_cnt, stay in green.
  - ext_cnt clears on every green entry.
- The all-red clearance between conflicting greens is never skipped. Both green outputs are never high together (assertion-checked).

Optional Feature:
SCHED_GAPOUT_EN
- Defined: green extension logic and ext_cnt as described above.
- Undefined: fixed-time plan. ns_car and ew_car are ignored (ports remain), and ext_cnt and MAX_EXT are unused.
- With defaults and no pedestrian request, one cycle round is 22 cycles.

Decomposition:
- Package tlc_pkg: state enum with the fixed codes above, and a phase-to-lamp decode function.
- Sub-module phase_timer:
  - CNT_W down-counter; inputs load, load_val; output done (count==0).
  - Same clk/rst convention; resets to 0.

Test Plan:
- Reset, release, no sensors or requests, SCHED_GAPOUT_EN undefined -> NS green cycles 1-8, NS yellow 9-10, all-red 11, EW green 12-19, EW yellow 20-21, all-red 22, NS green again at cycle 23.
- One-cycle ped_req pulse during EW_GREEN -> after ALLRED_B: walk=1 for 4 cycles, ped_ack high only in the first, both heads red, then NS_GREEN.
- SCHED_GAPOUT_EN, ew_car=0, ns_car=1 -> NS green lasts 8*(1+2)=24 cycles; raising ew_car mid-extension ends it at the next timer expiry.
- ped_req held high across the PED_WALK entry edge -> pending re-set, second walk phase exactly one round later.
- Assert rst mid-NS_GREEN, asynchronously between edges -> outputs immediately all-red with walk=0 and phase=5; restart sequence matches the first scenario.
- Every cycle of every test -> never (ns_green|ns_yellow) & (ew_green|ew_yellow), never walk with any green, exactly one lamp per head.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types for the intersection phase scheduler.
//   phase_t      : controller states with fixed codes. Code 7 is unused and
//                  is treated as illegal by the scheduler.
//   lamps_t      : one bit per lamp. There are two signal heads (NS, EW) and
//                  one walk lamp.
//   decode_lamps : maps a state code to its lamp pattern. An unknown code
//                  decodes to all-red with the walk lamp off.
package tlc_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6
  } phase_t;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;
  } lamps_t;

  // Each head shows red unless the state is its own green or yellow.
  function automatic lamps_t decode_lamps(input phase_t p);
    lamps_t l;
    l = '{ns_red: 1'b1, ns_yellow: 1'b0, ns_green: 1'b0,
          ew_red: 1'b1, ew_yellow: 1'b0, ew_green: 1'b0, walk: 1'b0};
    case (p)
      NS_GREEN:  begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
      NS_YELLOW: begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
      EW_GREEN:  begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
      EW_YELLOW: begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
      PED_WALK:  l.walk = 1'b1;
      default:   ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter that times how long the scheduler stays in each state.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset; the count resets to 0
//   load     : loads load_val on the next edge, which takes priority over
//              counting down
//   load_val : value to load, equal to the state duration minus 1
//   done     : high while the count is zero
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // The counter stops at zero. The owner reloads it on the edge where
  // done is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer with a pedestrian walk phase.
// It is a Moore FSM with one shared phase_timer. The state runs through
// NS green/yellow, all-red, EW green/yellow, all-red, and then an optional
// walk phase.
//   clk, rst          : clock; asynchronous active-high reset
//   ns_car, ew_car    : vehicle sensors (only used when gap-out is built in)
//   ped_req           : pedestrian request; it is latched into ped_pend
//   ped_ack           : registered one-cycle pulse in the first walk cycle
//   ns_*/ew_* lamps   : signal heads; walk : walk lamp; phase : state code
// Optional build macro SCHED_GAPOUT_EN adds vehicle-actuated green
// extension. Without it, the controller runs a fixed-time plan.
module intersection_phase_scheduler #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 4,
  parameter int MAX_EXT    = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] phase
);
  import tlc_pkg::*;

  phase_t           state, next_state;
  logic             timer_done, timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             ped_pend, ped_pend_next, entering_walk;
  logic             extend, illegal;
  lamps_t           lamps;

  function automatic logic [CNT_W-1:0] dur_m1(input phase_t p);
    case (p)
      NS_GREEN, EW_GREEN:   return CNT_W'(GREEN_CYC - 1);
      NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW_CYC - 1);
      PED_WALK:             return CNT_W'(WALK_CYC - 1);
      default:              return CNT_W'(ALLRED_CYC - 1);
    endcase
  endfunction

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

`ifdef SCHED_GAPOUT_EN
  localparam int EXT_W = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);
  logic [EXT_W-1:0] ext_cnt;

  // A green is extended only when the opposing road is empty and no
  // pedestrian is waiting. A pending walk always forces the cycle onward.
  always_comb begin
    extend = 1'b0;
    if (timer_done && !ped_pend && (int'(ext_cnt) < MAX_EXT)) begin
      if (state == NS_GREEN)
        extend = !ew_car;
      else if (state == EW_GREEN)
        extend = !ns_car;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ext_cnt <= '0;
    else if ((next_state != state) &&
             (next_state == NS_GREEN || next_state == EW_GREEN))
      ext_cnt <= '0;
    else if (extend)
      ext_cnt <= ext_cnt + 1'b1;
  end
`else
  logic unused_cfg;
  assign extend     = 1'b0;
  assign unused_cfg = ns_car ^ ew_car ^ (MAX_EXT != 0);
`endif

  // State register, pedestrian latch and the registered acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ALLRED_B;
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      state    <= next_state;
      ped_pend <= ped_pend_next;
      ped_ack  <= entering_walk;
    end
  end

  // Next state and timer reload. The state can change only when the timer
  // expires. An illegal code recovers to ALLRED_B with an expired timer.
  // ped_req is OR'd with ped_pend so that a request arriving in the last
  // all-red cycle is still served in this round.
  always_comb begin
    next_state = state;
    illegal    = 1'b0;
    case (state)
      NS_GREEN:  if (timer_done) next_state = extend ? NS_GREEN : NS_YELLOW;
      NS_YELLOW: if (timer_done) next_state = ALLRED_A;
      ALLRED_A:  if (timer_done) next_state = EW_GREEN;
      EW_GREEN:  if (timer_done) next_state = extend ? EW_GREEN : EW_YELLOW;
      EW_YELLOW: if (timer_done) next_state = ALLRED_B;
      ALLRED_B:  if (timer_done) next_state = (ped_pend || ped_req) ? PED_WALK : NS_GREEN;
      PED_WALK:  if (timer_done) next_state = NS_GREEN;
      default: begin
        next_state = ALLRED_B;
        illegal    = 1'b1;
      end
    endcase
    timer_load    = timer_done || illegal;
    timer_val     = illegal ? '0 : dur_m1(next_state);
    entering_walk = (state != PED_WALK) && (next_state == PED_WALK);
    // A request on the edge into the walk phase stays latched for the
    // next round.
    ped_pend_next = entering_walk ? ped_req : (ped_pend || ped_req);
  end

  // Moore lamp outputs decoded from the state register alone.
  always_comb begin
    lamps     = decode_lamps(state);
    ns_red    = lamps.ns_red;
    ns_yellow = lamps.ns_yellow;
    ns_green  = lamps.ns_green;
    ew_red    = lamps.ew_red;
    ew_yellow = lamps.ew_yellow;
    ew_green  = lamps.ew_green;
    walk      = lamps.walk;
    phase     = state;
  end

  a_no_dual_green: assert property (@(posedge clk) disable iff (rst)
    !(ns_green && ew_green));

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler (default parameters).
// The stimulus tasks push one expected state code and ped_ack value per clock
// cycle into a queue. The monitor pops one entry on every falling edge and
// compares it with the DUT outputs. The monitor also checks the lamp safety
// rules on every cycle.
module tb_intersection_phase_scheduler;

  localparam logic [2:0] P_NSG = 3'd0, P_NSY = 3'd1, P_ARA = 3'd2,
                         P_EWG = 3'd3, P_EWY = 3'd4, P_ARB = 3'd5, P_WLK = 3'd6;

`ifdef SCHED_GAPOUT_EN
  localparam bit SENSE_IDLE = 1'b1;
`else
  localparam bit SENSE_IDLE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ns_car = SENSE_IDLE;
  logic ew_car = SENSE_IDLE;
  logic ped_req = 1'b0;
  logic ped_ack, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic [2:0] phase;

  typedef struct {
    logic [2:0] phase;
    logic       ack;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  intersection_phase_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .ns_car    (ns_car),
    .ew_car    (ew_car),
    .ped_req   (ped_req),
    .ped_ack   (ped_ack),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .walk      (walk),
    .phase     (phase)
  );

  // Lamp pattern {ns r,y,g, ew r,y,g, walk} expected for each state code.
  function automatic logic [6:0] lamp_vec(input logic [2:0] p);
    case (p)
      P_NSG:   return 7'b001_100_0;
      P_NSY:   return 7'b010_100_0;
      P_EWG:   return 7'b100_001_0;
      P_EWY:   return 7'b100_010_0;
      P_WLK:   return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [6:0] act;
    act = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
    checks++;
    if (phase !== e.phase) begin
      errors++;
      $display("[TB] FAIL phase %s: got %0d want %0d", e.tag, phase, e.phase);
    end
    checks++;
    if (act !== lamp_vec(e.phase)) begin
      errors++;
      $display("[TB] FAIL lamps %s: got %b want %b", e.tag, act, lamp_vec(e.phase));
    end
    checks++;
    if (ped_ack !== e.ack) begin
      errors++;
      $display("[TB] FAIL ped_ack %s: got %b want %b", e.tag, ped_ack, e.ack);
    end
  endtask

  // Sample in mid-cycle, away from the active clock edge.
  always @(negedge clk) begin
    checks++;
    if (((ns_green | ns_yellow) & (ew_green | ew_yellow)) !== 1'b0 ||
        (walk & (ns_green | ew_green | ns_yellow | ew_yellow)) !== 1'b0 ||
        !$onehot({ns_red, ns_yellow, ns_green}) ||
        !$onehot({ew_red, ew_yellow, ew_green})) begin
      errors++;
      $display("[TB] FAIL safety at %0t: ns=%b%b%b ew=%b%b%b walk=%b want one-hot heads, no conflict",
               $time, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk);
    end
    if (exp_q.size() > 0)
      checkOutput(exp_q.pop_front());
  end

  // Holds ped_req high only in cycle ped_cycle (-1 means never) and queues
  // n expected cycles of state p.
  task automatic applyStimulus(input logic [2:0] p, input int n, input bit ack_first,
                               input int ped_cycle, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ped_req = (i == ped_cycle);
      exp_q.push_back('{phase: p, ack: (ack_first && i == 0), tag: $sformatf("%s/%0d", tag, i)});
    end
  endtask

  // Asserts reset between edges, then releases it one cycle later.
  task automatic resetRelease(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ped_req = 1'b0;
    exp_q.push_back('{phase: P_ARB, ack: 1'b0, tag: {tag, "/rst"}});
    @(posedge clk);
    #1;
    exp_q.push_back('{phase: P_ARB, ack: 1'b0, tag: {tag, "/rst2"}});
    rst = 1'b0;
  endtask

  task automatic fullRound(input bit walk_after, input int ew_ped, input int ar_ped,
                           input string tag);
    applyStimulus(P_NSG, 8, 1'b0, -1, {tag, "/nsg"});
    applyStimulus(P_NSY, 2, 1'b0, -1, {tag, "/nsy"});
    applyStimulus(P_ARA, 1, 1'b0, -1, {tag, "/ara"});
    applyStimulus(P_EWG, 8, 1'b0, ew_ped, {tag, "/ewg"});
    applyStimulus(P_EWY, 2, 1'b0, -1, {tag, "/ewy"});
    applyStimulus(P_ARB, 1, 1'b0, ar_ped, {tag, "/arb"});
    if (walk_after)
      applyStimulus(P_WLK, 4, 1'b1, -1, {tag, "/walk"});
  endtask

  initial begin
    // Fixed 22-cycle round after reset.
    resetRelease("s1");
    fullRound(1'b0, -1, -1, "s1");
    // A ped pulse in EW green gives a walk phase after ALLRED_B.
    fullRound(1'b1, 3, -1, "s2");
    // A request on the walk entry edge re-arms the walk for the next round.
    fullRound(1'b1, -1, 0, "s4a");
    fullRound(1'b1, -1, -1, "s4b");
    fullRound(1'b0, -1, -1, "s4c");
    // Asynchronous reset in the middle of NS green, then the same restart.
    applyStimulus(P_NSG, 3, 1'b0, -1, "s5pre");
    resetRelease("s5");
    fullRound(1'b0, -1, -1, "s5");
    applyStimulus(P_NSG, 1, 1'b0, -1, "s5next");
`ifdef SCHED_GAPOUT_EN
    // Gap-out: NS is extended twice while EW is empty.
    ns_car = 1'b1;
    ew_car = 1'b0;
    resetRelease("g");
    applyStimulus(P_NSG, 24, 1'b0, -1, "g/nsg");
    applyStimulus(P_NSY, 2, 1'b0, -1, "g/nsy");
    applyStimulus(P_ARA, 1, 1'b0, -1, "g/ara");
    applyStimulus(P_EWG, 8, 1'b0, -1, "g/ewg");
    applyStimulus(P_EWY, 2, 1'b0, -1, "g/ewy");
    applyStimulus(P_ARB, 1, 1'b0, -1, "g/arb");
    applyStimulus(P_NSG, 9, 1'b0, -1, "g/nsg2a");
    ew_car = 1'b1;
    applyStimulus(P_NSG, 7, 1'b0, -1, "g/nsg2b");
    applyStimulus(P_NSY, 2, 1'b0, -1, "g/nsy2");
`endif
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
